// File: rtl/pattern_matcher_pkg.sv
// Shared constants and helpers for the runtime-programmable byte pattern matcher.
// Reset defaults reproduce the legacy "MARCO" keyword detector.
package pattern_matcher_pkg;

    localparam int                      DEFAULT_LEN     = 5;
    localparam logic [8*DEFAULT_LEN-1:0] DEFAULT_PATTERN = "MARCO";

    localparam logic [7:0] ASCII_LOWER_A  = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z  = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    function automatic logic [7:0] ascii_fold(input logic [7:0] b, input logic enable);
        if (enable && (b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z))
            return b - ASCII_CASE_BIT;
        return b;
    endfunction

    // Character idx of the default pattern; the string literal keeps its first character in the MSBs.
    function automatic logic [7:0] default_char(input int idx);
        if (idx < DEFAULT_LEN)
            return DEFAULT_PATTERN[8*(DEFAULT_LEN-1-idx) +: 8];
        return 8'h00;
    endfunction

endpackage

// File: rtl/pm_pos_cmp.sv
// Single pattern-position comparator: wildcard, optional ASCII case folding, equality.
module pm_pos_cmp
    import pattern_matcher_pkg::*;
(
    input  logic       i_care,
    input  logic [7:0] i_pat,
    input  logic [7:0] i_data,
    input  logic       i_fold_en,
    output logic       o_hit
);

    assign o_hit = !i_care || (ascii_fold(i_data, i_fold_en) == ascii_fold(i_pat, i_fold_en));

endmodule

// File: rtl/pattern_matcher.sv
// Byte-stream pattern matcher: keeps the last MAX_LEN bytes and flags when the newest
// window equals a programmable pattern (wildcards, case folding, optional non-overlap).
module pattern_matcher
    import pattern_matcher_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         new_byte,
    input  logic [7:0]                   the_byte,
    input  logic                         cfg_we,
    input  logic [$clog2(MAX_LEN)-1:0]   cfg_addr,
    input  logic [7:0]                   cfg_data,
    input  logic                         cfg_care,
    input  logic                         cfg_len_we,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_case_insens,
    input  logic                         cfg_no_overlap,
    input  logic                         cnt_clr,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(MAX_LEN+1)-1:0] fill
);

    localparam int               LW        = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0]    MAX_FILL  = LW'(MAX_LEN);
    localparam logic [LW-1:0]    RESET_LEN = LW'(DEFAULT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    if (MAX_LEN < 5) begin : g_bad_max_len
        $error("pattern_matcher: MAX_LEN must be >= 5");
    end

    logic [7:0]         r_hist [MAX_LEN];
    logic [7:0]         r_pat  [MAX_LEN];
    logic [MAX_LEN-1:0] r_care;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;

    logic [7:0]         w_win [MAX_LEN];
    logic [7:0]         w_sel [MAX_LEN];
    logic [MAX_LEN-1:0] w_cmp_hit;
    logic [MAX_LEN-1:0] w_pos_hit;
    logic               w_cfg_wr;
    logic               w_addr_ok;
    logic               w_len_ok;
    logic               w_fill_ok;
    logic               w_match_now;

    // The window already includes the byte arriving this cycle, so a match needs no extra latency.
    always_comb begin
        for (int j = 0; j < MAX_LEN - 1; j++)
            w_win[j] = r_hist[j + 1];
        w_win[MAX_LEN-1] = the_byte;
    end

    // Pattern position i lines up with window slot MAX_LEN-len+i (right-aligned to the newest byte).
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            // NOTE: every combinational output gets a default before any conditional assignment, so no latch is inferred.
            w_sel[i] = '0;
            for (int j = 0; j < MAX_LEN; j++) begin
                if (j + int'(r_len) == MAX_LEN + i)
                    w_sel[i] = w_win[j];
            end
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pos
        pm_pos_cmp u_cmp (
            .i_care    (r_care[g]),
            .i_pat     (r_pat[g]),
            .i_data    (w_sel[g]),
            .i_fold_en (cfg_case_insens),
            .o_hit     (w_cmp_hit[g])
        );
        assign w_pos_hit[g] = w_cmp_hit[g] || (g >= int'(r_len));
    end

    assign w_cfg_wr    = cfg_we || cfg_len_we;
    assign w_addr_ok   = int'(cfg_addr) < MAX_LEN;
    assign w_len_ok    = (r_len != '0) && (int'(r_len) <= MAX_LEN);
    assign w_fill_ok   = (int'(r_fill) + 1) >= int'(r_len);
    assign w_match_now = new_byte && (&w_pos_hit) && w_fill_ok && w_len_ok && !w_cfg_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: history and pattern arrays are reset explicitly; a mid-run reset must restore the legacy keyword and clear stale bytes.
            for (int i = 0; i < MAX_LEN; i++) begin
                r_hist[i] <= '0;
                r_pat[i]  <= default_char(i);
                r_care[i] <= (i < DEFAULT_LEN);
            end
            r_len <= RESET_LEN;
        end else begin
            // NOTE: state updates use non-blocking assignments so the shift reads the pre-edge history.
            if (new_byte) begin
                for (int j = 0; j < MAX_LEN - 1; j++)
                    r_hist[j] <= r_hist[j + 1];
                r_hist[MAX_LEN-1] <= the_byte;
            end
            if (cfg_we && w_addr_ok) begin
                r_pat[cfg_addr]  <= cfg_data;
                r_care[cfg_addr] <= cfg_care;
            end
            if (cfg_len_we)
                r_len <= cfg_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill  <= '0;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            r_match <= w_match_now;

            if (w_cfg_wr)
                r_fill <= '0;
            else if (new_byte) begin
                if (w_match_now && cfg_no_overlap)
                    r_fill <= '0;
                else if (r_fill != MAX_FILL)
                    r_fill <= r_fill + 1'b1;
            end

            if (cnt_clr)
                r_count <= '0;
            else if (w_match_now && (r_count != CNT_MAX))
                r_count <= r_count + 1'b1;
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign fill        = r_fill;

endmodule

// File: tb/tb_pattern_matcher.sv
// Directed bench for pattern_matcher (MAX_LEN = 8, CNT_W = 2 so counter saturation is reachable).
module tb_pattern_matcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_byte = 1'b0;
    logic [7:0] the_byte = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       cfg_care = 1'b0;
    logic       cfg_len_we = 1'b0;
    logic [3:0] cfg_len = '0;
    logic       cfg_case_insens = 1'b0;
    logic       cfg_no_overlap = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       match;
    logic [1:0] match_count;
    logic [3:0] fill;

    int n_pass = 0;
    int n_total = 0;

    pattern_matcher #(.MAX_LEN(8), .CNT_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .new_byte        (new_byte),
        .the_byte        (the_byte),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .cfg_care        (cfg_care),
        .cfg_len_we      (cfg_len_we),
        .cfg_len         (cfg_len),
        .cfg_case_insens (cfg_case_insens),
        .cfg_no_overlap  (cfg_no_overlap),
        .cnt_clr         (cnt_clr),
        .match           (match),
        .match_count     (match_count),
        .fill            (fill)
    );

    always #5 clk = ~clk;

    // All tasks start and end on a falling edge; inputs change there and outputs are sampled there.
    task automatic send_byte(input logic [7:0] b, output logic m);
        new_byte = 1'b1;
        the_byte = b;
        @(negedge clk);
        m = match;
        new_byte = 1'b0;
    endtask

    task automatic send_str(input string s, output logic [31:0] mask);
        logic m;
        mask = '0;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], m);
            mask[i] = m;
        end
    endtask

    task automatic write_pat(input logic [2:0] addr, input logic [7:0] data, input logic care);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        cfg_care = care;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic write_len(input logic [3:0] len);
        cfg_len_we = 1'b1;
        cfg_len    = len;
        @(negedge clk);
        cfg_len_we = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++; if (match !== 1'b0) $display("FAIL reset_match: got %0h want 0", match); else n_pass++;
        n_total++; if (match_count !== 2'd0) $display("FAIL reset_count: got %0d want 0", match_count); else n_pass++;
        n_total++; if (fill !== 4'd0) $display("FAIL reset_fill: got %0d want 0", fill); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (fill !== 4'd0) $display("FAIL post_reset_fill: got %0d want 0", fill); else n_pass++;
    endtask

    task automatic test_default_marco();
        logic [31:0] mask;
        send_str("xMARCO", mask);
        n_total++; if (mask !== 32'h20) $display("FAIL marco_pulses: got %0h want 20", mask); else n_pass++;
        n_total++; if (match_count !== 2'd1) $display("FAIL marco_count: got %0d want 1", match_count); else n_pass++;
        n_total++; if (fill !== 4'd6) $display("FAIL marco_fill: got %0d want 6", fill); else n_pass++;
        @(negedge clk);
        n_total++; if (match !== 1'b0) $display("FAIL marco_one_cycle: got %0h want 0", match); else n_pass++;
        send_str("MARC", mask);
        n_total++; if (mask !== 32'h0) $display("FAIL marc_no_pulse: got %0h want 0", mask); else n_pass++;
        n_total++; if (match_count !== 2'd1) $display("FAIL marc_count: got %0d want 1", match_count); else n_pass++;
    endtask

    task automatic test_reprogram();
        logic [31:0] mask;
        write_pat(3'd0, "P", 1'b1);
        write_pat(3'd1, "O", 1'b1);
        write_pat(3'd2, "L", 1'b1);
        write_len(4'd3);
        n_total++; if (fill !== 4'd0) $display("FAIL cfg_fill_clear: got %0d want 0", fill); else n_pass++;
        send_str("POLPOL", mask);
        n_total++; if (mask !== 32'h24) $display("FAIL polpol_pulses: got %0h want 24", mask); else n_pass++;

        write_pat(3'd0, "A", 1'b1);
        write_pat(3'd1, "A", 1'b1);
        write_len(4'd2);
        cfg_no_overlap = 1'b1;
        send_str("AAAA", mask);
        n_total++; if (mask !== 32'hA) $display("FAIL no_overlap_pulses: got %0h want a", mask); else n_pass++;
        n_total++; if (fill !== 4'd0) $display("FAIL no_overlap_fill: got %0d want 0", fill); else n_pass++;
        cfg_no_overlap = 1'b0;
        write_len(4'd2);
        send_str("AAAA", mask);
        n_total++; if (mask !== 32'hE) $display("FAIL overlap_pulses: got %0h want e", mask); else n_pass++;
    endtask

    task automatic test_wildcard_case();
        logic [31:0] mask;
        write_pat(3'd0, "M", 1'b1);
        write_pat(3'd1, "Z", 1'b0);
        write_pat(3'd2, "R", 1'b1);
        write_pat(3'd3, "C", 1'b1);
        write_pat(3'd4, "O", 1'b1);
        write_len(4'd5);
        cfg_case_insens = 1'b1;
        send_str("mxrco", mask);
        n_total++; if (mask !== 32'h10) $display("FAIL case_insens_pulse: got %0h want 10", mask); else n_pass++;
        cfg_case_insens = 1'b0;
        send_str("mxrco", mask);
        n_total++; if (mask !== 32'h0) $display("FAIL case_sens_no_pulse: got %0h want 0", mask); else n_pass++;
        send_str("MxRCO", mask);
        n_total++; if (mask !== 32'h10) $display("FAIL wildcard_pulse: got %0h want 10", mask); else n_pass++;
    endtask

    task automatic test_fill_gating();
        logic [31:0] mask;
        logic        m;
        apply_reset();
        for (int i = 0; i < 5; i++)
            write_pat(3'(i), 8'h00, 1'b1);
        write_len(4'd5);
        mask = '0;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h00, m);
            mask[i] = m;
        end
        n_total++; if (mask !== 32'h10) $display("FAIL fill_gating_pulses: got %0h want 10", mask); else n_pass++;
    endtask

    task automatic test_config_collision();
        logic [31:0] mask;
        logic        m;
        apply_reset();
        send_str("MARC", mask);
        n_total++; if (mask !== 32'h0) $display("FAIL collision_prefix: got %0h want 0", mask); else n_pass++;
        new_byte = 1'b1;
        the_byte = "O";
        cfg_we   = 1'b1;
        cfg_addr = 3'd5;
        cfg_data = 8'h00;
        cfg_care = 1'b0;
        @(negedge clk);
        m = match;
        new_byte = 1'b0;
        cfg_we   = 1'b0;
        n_total++; if (m !== 1'b0) $display("FAIL collision_no_pulse: got %0h want 0", m); else n_pass++;
        n_total++; if (fill !== 4'd0) $display("FAIL collision_fill: got %0d want 0", fill); else n_pass++;

        write_len(4'd0);
        send_str("MARCOMARCO", mask);
        n_total++; if (mask !== 32'h0) $display("FAIL len0_no_pulse: got %0h want 0", mask); else n_pass++;
        n_total++; if (fill !== 4'd8) $display("FAIL fill_saturate: got %0d want 8", fill); else n_pass++;
        write_len(4'd9);
        send_str("MARCOMARCO", mask);
        n_total++; if (mask !== 32'h0) $display("FAIL len9_no_pulse: got %0h want 0", mask); else n_pass++;
    endtask

    task automatic test_counter();
        logic [31:0] mask;
        logic        m;
        logic [1:0]  c;
        apply_reset();
        send_str("MARCOMARCOMARCOMARCOMARCO", mask);
        n_total++; if (mask !== 32'h01084210) $display("FAIL five_pulses: got %0h want 1084210", mask); else n_pass++;
        n_total++; if (match_count !== 2'd3) $display("FAIL count_saturate: got %0d want 3", match_count); else n_pass++;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        n_total++; if (match_count !== 2'd0) $display("FAIL count_clear: got %0d want 0", match_count); else n_pass++;

        send_str("MARC", mask);
        new_byte = 1'b1;
        the_byte = "O";
        cnt_clr  = 1'b1;
        @(negedge clk);
        m = match;
        c = match_count;
        new_byte = 1'b0;
        cnt_clr  = 1'b0;
        n_total++; if (m !== 1'b1) $display("FAIL clr_with_pulse_match: got %0h want 1", m); else n_pass++;
        n_total++; if (c !== 2'd0) $display("FAIL clr_priority: got %0d want 0", c); else n_pass++;
        @(negedge clk);
        n_total++; if (match_count !== 2'd0) $display("FAIL clr_after: got %0d want 0", match_count); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] mask;
        write_pat(3'd0, "P", 1'b1);
        write_pat(3'd1, "O", 1'b1);
        write_pat(3'd2, "L", 1'b1);
        write_len(4'd3);
        send_str("MAR", mask);
        apply_reset();
        n_total++; if (fill !== 4'd0) $display("FAIL mid_reset_fill: got %0d want 0", fill); else n_pass++;
        send_str("CO", mask);
        n_total++; if (mask !== 32'h0) $display("FAIL mid_reset_no_pulse: got %0h want 0", mask); else n_pass++;
        send_str("MARCO", mask);
        n_total++; if (mask !== 32'h10) $display("FAIL default_restored: got %0h want 10", mask); else n_pass++;
        n_total++; if (match_count !== 2'd1) $display("FAIL mid_reset_count: got %0d want 1", match_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default_marco();
        test_reprogram();
        test_wildcard_case();
        test_fill_gating();
        test_config_collision();
        test_counter();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
